// File: rtl/out_channel_arbiter_if.sv
// rtl/out_channel_arbiter_if.sv - request handshake and out-memory write bus
// Ports (signals):
//   req_valid  [NReq]        requester holds a word
//   req_data   [NReq*Width]  word of requester i at [i*Width +: Width]
//   req_ready  [NReq]        one-hot grant
//   out_wr                   registered write strobe
//   out_addr   [clog2(NOut+1)] registered write address
//   out_data   [Width]       registered write data
// Modports: master drives requests, slave is the arbiter.
interface out_channel_arbiter_if #(
  parameter int NReq  = 4,
  parameter int Width = 12,
  parameter int NOut  = 16
);
  logic [NReq-1:0]            req_valid;
  logic [NReq*Width-1:0]      req_data;
  logic [NReq-1:0]            req_ready;
  logic                       out_wr;
  logic [$clog2(NOut+1)-1:0]  out_addr;
  logic [Width-1:0]           out_data;

  modport master (
    output req_valid, req_data,
    input  req_ready, out_wr, out_addr, out_data
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, out_wr, out_addr, out_data
  );
endinterface

// File: rtl/out_channel_arbiter.sv
// rtl/out_channel_arbiter.sv - round-robin arbiter of NReq requesters onto an NOut-slot out channel
// Ports:
//   clock, reset   posedge clock, synchronous active-high reset
//   bus            out_channel_arbiter_if.slave (requests in, grants and write bus out)
//   out_pos        words written so far
//   full           out_pos == NOut
//   overflow       sticky: a request arrived while full
//   word_count     per-requester 8-bit accepted-word counters
// Optional feature: define OUT_CHANNEL_ARBITER_COUNT_EN to enable word_count counters;
// otherwise word_count is tied to zero.
module out_channel_arbiter #(
  parameter int NReq  = 4,
  parameter int Width = 12,
  parameter int NOut  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  out_channel_arbiter_if.slave       bus,
  output logic [$clog2(NOut+1)-1:0]  out_pos,
  output logic                       full,
  output logic                       overflow,
  output logic [NReq*8-1:0]          word_count
);
  localparam int PosW = $clog2(NOut+1);
  localparam int PtrW = $clog2(NReq);
  localparam logic [PosW-1:0] NOutP = PosW'(NOut);
  localparam logic [PtrW-1:0] LastP = PtrW'(NReq - 1);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_FULL} state_t;

  state_t             state_q, state_d;
  logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PosW-1:0]    out_pos_q, out_pos_d;
  logic               out_wr_q, out_wr_d;
  logic [PosW-1:0]    out_addr_q, out_addr_d;
  logic [Width-1:0]   out_data_q, out_data_d;
  logic               overflow_q, overflow_d;

  logic               grant_found;
  logic [PtrW-1:0]    grant_idx;
  logic [PtrW-1:0]    scan_idx;
  logic [NReq-1:0]    ready;
  logic               transfer;
  logic               any_valid;

  assign any_valid = |bus.req_valid;

  // Scan requesters starting at rr_ptr, wrapping; first valid one wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NReq; k++) begin
      scan_idx = PtrW'((int'(rr_ptr_q) + k) % NReq);
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    ready = '0;
    if (grant_found && state_q != S_FULL && !reset) begin
      ready[grant_idx] = 1'b1;
    end
  end

  assign transfer = |ready;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    out_pos_d  = out_pos_q;
    out_wr_d   = transfer;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    overflow_d = overflow_q;

    if (transfer) begin
      rr_ptr_d   = (grant_idx == LastP) ? '0 : grant_idx + PtrW'(1);
      out_addr_d = out_pos_q;
      out_data_d = bus.req_data[grant_idx*Width +: Width];
      if (out_pos_q != NOutP) begin
        out_pos_d = out_pos_q + PosW'(1);
      end
    end

    if (state_q == S_FULL && any_valid) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (out_pos_d == NOutP) state_d = S_FULL;
        else if (any_valid)     state_d = S_SERVE;
      end
      S_SERVE: begin
        if (out_pos_d == NOutP) state_d = S_FULL;
        else if (!any_valid)    state_d = S_IDLE;
      end
      S_FULL:  state_d = S_FULL;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      out_pos_q  <= '0;
      out_wr_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      out_pos_q  <= out_pos_d;
      out_wr_q   <= out_wr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef OUT_CHANNEL_ARBITER_COUNT_EN
  logic [NReq*8-1:0] word_count_q, word_count_d;

  // 8-bit fields wrap naturally at 255 -> 0.
  always_comb begin
    word_count_d = word_count_q;
    if (transfer) begin
      word_count_d[grant_idx*8 +: 8] = word_count_q[grant_idx*8 +: 8] + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) word_count_q <= '0;
    else       word_count_q <= word_count_d;
  end

  assign word_count = word_count_q;
`else
  assign word_count = '0;
`endif

  assign bus.req_ready = ready;
  assign bus.out_wr    = out_wr_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign out_pos       = out_pos_q;
  assign full          = (out_pos_q == NOutP);
  assign overflow      = overflow_q;
endmodule

// File: tb/tb_out_channel_arbiter.sv
// tb/tb_out_channel_arbiter.sv - directed self-checking bench for out_channel_arbiter
module tb_out_channel_arbiter;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  out_channel_arbiter_if #(.NReq(4), .Width(12), .NOut(16))  bus();
  out_channel_arbiter_if #(.NReq(4), .Width(12), .NOut(511)) bus2();

  logic [4:0]  out_pos;
  logic        full, overflow;
  logic [31:0] word_count;
  logic [9:0]  out_pos2;
  logic        full2, overflow2;
  logic [31:0] word_count2;

  out_channel_arbiter #(.NReq(4), .Width(12), .NOut(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .out_pos    (out_pos),
    .full       (full),
    .overflow   (overflow),
    .word_count (word_count)
  );

  out_channel_arbiter #(.NReq(4), .Width(12), .NOut(511)) dut_cnt (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus2),
    .out_pos    (out_pos2),
    .full       (full2),
    .overflow   (overflow2),
    .word_count (word_count2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus2.req_valid = '0;
    bus2.req_data  = '0;

    // Reset state, with requests pending to show grants are suppressed.
    bus.req_valid = 4'b1111;
    step();
    step();
    #1;
    check("rst_ready",    bus.req_ready, 4'b0000);
    check("rst_out_wr",   bus.out_wr, 0);
    check("rst_out_addr", bus.out_addr, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_pos",  out_pos, 0);
    check("rst_full",     full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_wcount",   word_count, 0);
    reset = 1'b0;
    bus.req_valid = '0;
    step();
    check("idle_out_wr", bus.out_wr, 0);

    // Single requester: data 1,2,3 to addresses 0,1,2.
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      bus.req_data[11:0] = 12'(i + 1);
      #1;
      check("single_ready", bus.req_ready, 4'b0001);
      step();
      check("single_wr",   bus.out_wr, 1);
      check("single_addr", bus.out_addr, i);
      check("single_data", bus.out_data, i + 1);
    end
    bus.req_valid = '0;
    #1;
    check("single_pos", out_pos, 3);
    step();
    check("single_wr_low", bus.out_wr, 0);

    // Round robin across all four requesters.
    do_reset();
    for (int i = 0; i < 4; i++) bus.req_data[i*12 +: 12] = 12'(10 + i);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_ready", bus.req_ready, 4'b0001 << (k % 4));
      step();
      check("rr_data", bus.out_data, 10 + (k % 4));
      check("rr_addr", bus.out_addr, k);
    end
    bus.req_valid = '0;
    check("rr_pos", out_pos, 8);

    // Fill from requester 2, then overflow.
    do_reset();
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 16; k++) begin
      bus.req_data[24 +: 12] = 12'(100 + k);
      #1;
      check("fill_ready", bus.req_ready, 4'b0100);
      step();
      check("fill_addr", bus.out_addr, k);
      check("fill_data", bus.out_data, 100 + k);
    end
    check("fill_full",      full, 1);
    check("fill_pos",       out_pos, 16);
    check("fill_ready_off", bus.req_ready, 4'b0000);
    check("fill_ovf_early", overflow, 0);
    step();
    check("fill_overflow", overflow, 1);
    check("fill_wr_low",   bus.out_wr, 0);
    check("fill_ready_z",  bus.req_ready, 4'b0000);
    bus.req_valid = '0;
    step();
    check("fill_ovf_sticky", overflow, 1);

    // Last-slot contention: 15 words from requester 1 leave rr_ptr at 2.
    do_reset();
    bus.req_valid = 4'b0010;
    for (int k = 0; k < 15; k++) step();
    bus.req_valid = '0;
    check("last_pos15", out_pos, 15);
    check("last_notfull", full, 0);
    bus.req_data[12 +: 12] = 12'h111;
    bus.req_data[36 +: 12] = 12'h333;
    bus.req_valid = 4'b1010;
    #1;
    check("last_ready", bus.req_ready, 4'b1000);
    step();
    check("last_wr",    bus.out_wr, 1);
    check("last_addr",  bus.out_addr, 15);
    check("last_data",  bus.out_data, 12'h333);
    check("last_full",  full, 1);
    check("last_ready0", bus.req_ready, 4'b0000);
    bus.req_valid = '0;

    // Reset the cycle after a transfer.
    do_reset();
    bus.req_data[11:0] = 12'd77;
    bus.req_valid = 4'b0001;
    step();
    check("mid_wr_pending", bus.out_wr, 1);
    reset = 1'b1;
    bus.req_valid = '0;
    step();
    check("mid_wr_drop", bus.out_wr, 0);
    check("mid_pos",     out_pos, 0);
    check("mid_ovf",     overflow, 0);
    reset = 1'b0;
    bus.req_data[11:0]  = 12'd5;
    bus.req_data[23:12] = 12'd6;
    bus.req_valid = 4'b0011;
    #1;
    check("mid_rr_ptr0", bus.req_ready, 4'b0001);
    step();
    check("mid_wr",   bus.out_wr, 1);
    check("mid_addr", bus.out_addr, 0);
    check("mid_data", bus.out_data, 5);
    bus.req_valid = '0;

    // 300 transfers from requester 0 on the deep instance.
    do_reset();
    bus2.req_valid = 4'b0001;
    for (int k = 0; k < 300; k++) begin
      bus2.req_data[11:0] = 12'(k);
      step();
    end
    bus2.req_valid = '0;
    check("cnt_pos", out_pos2, 300);
    check("cnt_last_data", bus2.out_data, 299);
`ifdef OUT_CHANNEL_ARBITER_COUNT_EN
    check("cnt_wc0", word_count2[7:0], 44);
`else
    check("cnt_wc0", word_count2[7:0], 0);
`endif
    check("cnt_wc_others", word_count2[31:8], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/out_channel_arbiter.md
OUT_CHANNEL_ARBITER -- requirements
Module: out_channel_arbiter

Interface
REQ-001 SHALL have parameter NReq, default 4, number of requesters sharing the out channel (2..8).
REQ-002 SHALL have parameter Width, default 12, out-channel element width.
REQ-003 SHALL have parameter NOut, default 16, number of out-channel slots.
REQ-004 SHALL have port clock  input  1  driving clock; all state changes on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NReq  requester i holds a word to output.
REQ-007 SHALL have port req_data  input  NReq*Width  word of requester i at bits [i*Width +: Width].
REQ-008 SHALL have port req_ready  output  NReq  one-hot grant; transfer when req_valid[i] && req_ready[i].
REQ-009 SHALL have port out_wr  output  1  registered write strobe to out memory.
REQ-010 SHALL have port out_addr  output  clog2(NOut+1)  registered write address.
REQ-011 SHALL have port out_data  output  Width  registered write data.
REQ-012 SHALL have port out_pos  output  clog2(NOut+1)  number of words written so far.
REQ-013 SHALL have port full  output  1  high when out_pos == NOut.
REQ-014 SHALL have port overflow  output  1  sticky; a request was refused because the channel was full.
REQ-015 SHALL have port word_count  output  NReq*8  per-requester accepted-word counters.

Function
REQ-016 SHALL implement states IDLE (no req_valid), SERVE (at least one req_valid, not full), FULL (out_pos == NOut).
REQ-017 SHALL transition IDLE->SERVE on any req_valid, SERVE->IDLE when no req_valid and not full, and SERVE->FULL on the cycle out_pos reaches NOut; FULL is left only by reset.
REQ-018 SHALL drive req_ready combinationally: in SERVE or IDLE, exactly one bit for the first valid requester at or after rr_ptr (wrapping NReq-1 -> 0); all zero when no valid requester or in FULL.
REQ-019 SHALL, on a transfer from requester g, set rr_ptr to (g+1) mod NReq; rr_ptr SHALL be unchanged on cycles without a transfer.
REQ-020 SHALL accept at most one word per cycle, with one-cycle latency: the cycle after transfer, out_wr=1, out_addr=out_pos before increment, out_data=req_data of g.
REQ-021 SHALL increment out_pos by 1 per transfer, saturating at NOut.
REQ-022 SHALL, when full is high and any req_valid is high, set overflow to 1 and hold it until reset.
REQ-023 SHALL hold out_wr low on every cycle with no preceding transfer.
REQ-024 SHALL treat req_valid dropping without a transfer as no request; no state is retained for the requester.
REQ-025 SHALL grant the last free slot to exactly one requester when several are valid with out_pos == NOut-1; the others see req_ready=0.

Reset
REQ-026 SHALL, while reset is high, force state IDLE, rr_ptr=0, out_pos=0, out_wr=0, out_addr=0, out_data=0, full=0, overflow=0, word_count all 0, req_ready all 0.
REQ-027 SHALL, on reset asserted mid-transfer, discard the pending write: out_wr=0 on the following cycle.

Configuration
REQ-028 SHALL, with macro OUT_CHANNEL_ARBITER_COUNT_EN defined, increment the 8-bit word_count field of the granted requester on each transfer, wrapping 255 -> 0.
REQ-029 SHALL, without OUT_CHANNEL_ARBITER_COUNT_EN, tie word_count to 0 and contain no counter registers; all other behaviour is identical.

Verification
REQ-030 SHALL cover single requester: req_valid=0001, data 1,2,3 on consecutive cycles -> out_wr on three cycles, addresses 0,1,2, data 1,2,3, out_pos=3.
REQ-031 SHALL cover round robin: all four valid for 8 cycles, data[i]=10+i -> grant order 0,1,2,3,0,1,2,3; out_data 10,11,12,13,10,11,12,13.
REQ-032 SHALL cover fill: NOut=16, continuous valid on requester 2 -> full=1 after the 16th transfer, req_ready=0 afterwards, overflow=1 on the next cycle with valid still high.
REQ-033 SHALL cover last-slot contention: out_pos=15, requesters 1 and 3 valid, rr_ptr=2 -> only requester 3 granted, out_addr=15, full=1.
REQ-034 SHALL cover reset mid-operation: reset asserted the cycle after a transfer -> out_wr=0, out_pos=0, overflow=0, rr_ptr=0; a subsequent request is written at address 0.
REQ-035 SHALL cover, with OUT_CHANNEL_ARBITER_COUNT_EN, 300 transfers from requester 0 -> word_count[7:0]=44; without the macro -> word_count=0.
